// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared types and defaults for the interrupt / trap controller.
//   trap_state_e        : FSM state encoding (IDLE, ENTER, IN_TRAP, RETURN)
//   ECALL_CAUSE_DEF     : default cause code reported for ecall
//   IRQ_CAUSE_BASE_DEF  : default cause code for irq 0 (irq i -> base + i)
//   CAUSE_W_DEF/cause_t : default cause width and matching cause type
// -----------------------------------------------------------------------------
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_IN_TRAP = 2'd2,
    ST_RETURN  = 2'd3
  } trap_state_e;

  localparam int ECALL_CAUSE_DEF    = 11;
  localparam int IRQ_CAUSE_BASE_DEF = 16;
  localparam int CAUSE_W_DEF        = 5;

  typedef logic [CAUSE_W_DEF-1:0] cause_t;

endpackage

// File: rtl/irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// One interrupt source: SYNC_STAGES-flop synchronizer, rising-edge detector
// and a sticky pending flop for edge-triggered sources.
//   clk, rst_n  : clock, asynchronous active-low reset
//   irq_i       : raw request, asynchronous to clk
//   clear_i     : claim strobe, clears the edge-pending flop
//   pending_o   : edge source -> sticky pending flop
//                 level source -> synchronized request
// -----------------------------------------------------------------------------
module irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit IS_EDGE     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic clear_i,
  output logic pending_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pend_q;
  logic                   pend_d;
  logic                   sync_bit;
  logic                   rise;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign rise     = sync_bit & ~hist_q;

  // A new edge arriving in the claim cycle re-arms the flop (set wins).
  assign pend_d   = rise | (pend_q & ~clear_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      hist_q <= sync_bit;
      pend_q <= pend_d;
    end
  end

  assign pending_o = IS_EDGE ? pend_q : sync_bit;

endmodule

// File: rtl/irq_trap_ctrl.sv
// -----------------------------------------------------------------------------
// irq_trap_ctrl
// Single-level trap controller: synchronizes NUM_IRQ interrupt sources,
// arbitrates ecall vs. interrupts and sequences trap entry / return.
//   clk, rst_n        : clock, asynchronous active-low reset
//   irq               : raw interrupt requests (async)
//   irq_en            : per-source enable mask (mie)
//   global_ie         : global interrupt enable (mstatus.MIE)
//   ecall             : ecall request from decode
//   trap_ret          : mret request from decode (honoured only in IN_TRAP)
//   pipe_ready        : pipeline can accept a redirect
//   trapping          : handler active (ENTER or IN_TRAP)
//   trigger_trap      : one-cycle pulse in ENTER
//   trigger_trap_ret  : one-cycle pulse in RETURN
//   cause/cause_is_irq: cause of the current/last trap
//   irq_claim         : one-hot claimed source during an IRQ ENTER cycle
//   pending           : pending vector (mip view)
//   nested_err        : sticky, ecall seen while a trap was in progress
//   state_dbg         : FSM state, for observation
//
// Handshake: the only flow control is pipe_ready. Entry happens on the edge
// where pipe_ready and a request are both high; if pipe_ready is low the
// request is simply retained (pending stays set) and retried every cycle.
// -----------------------------------------------------------------------------
module irq_trap_ctrl
  import trap_pkg::*;
#(
  parameter int                 NUM_IRQ        = 4,
  parameter int                 SYNC_STAGES    = 2,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE       = '0,
  parameter int                 CAUSE_W        = 5,
  parameter int                 ECALL_CAUSE    = ECALL_CAUSE_DEF,
  parameter int                 IRQ_CAUSE_BASE = IRQ_CAUSE_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               global_ie,
  input  logic               ecall,
  input  logic               trap_ret,
  input  logic               pipe_ready,
  output logic               trapping,
  output logic               trigger_trap,
  output logic               trigger_trap_ret,
  output logic [CAUSE_W-1:0] cause,
  output logic               cause_is_irq,
  output logic [NUM_IRQ-1:0] irq_claim,
  output logic [NUM_IRQ-1:0] pending,
  output logic               nested_err,
  output logic [1:0]         state_dbg
);

  trap_state_e        state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               is_irq_q, is_irq_d;
  logic [NUM_IRQ-1:0] claim_q, claim_d;
  logic               nested_q, nested_d;

  logic [NUM_IRQ-1:0] enabled;
  logic               irq_req;
  logic [NUM_IRQ-1:0] sel_oh;
  int                 sel_idx;
  logic               found;

  // Per-source synchronizer / pending logic.
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq
    irq_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .IS_EDGE     (IRQ_EDGE[g])
    ) u_irq_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_i     (irq[g]),
      .clear_i   (irq_claim[g]),
      .pending_o (pending[g])
    );
  end

  assign enabled = pending & irq_en;
  assign irq_req = global_ie & (|enabled);

  // Lowest enabled pending index wins.
  always_comb begin
    sel_oh  = '0;
    sel_idx = 0;
    found   = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (enabled[i] && !found) begin
        found     = 1'b1;
        sel_idx   = i;
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    is_irq_d = is_irq_q;
    claim_d  = claim_q;
    nested_d = nested_q;
    case (state_q)
      ST_IDLE: begin
        if (pipe_ready && (ecall || irq_req)) begin
          state_d = ST_ENTER;
          if (ecall) begin
            cause_d  = CAUSE_W'(ECALL_CAUSE);
            is_irq_d = 1'b0;
            claim_d  = '0;
          end else begin
            cause_d  = CAUSE_W'(IRQ_CAUSE_BASE + sel_idx);
            is_irq_d = 1'b1;
            claim_d  = sel_oh;
          end
        end
      end
      ST_ENTER: begin
        state_d = ST_IN_TRAP;
        if (ecall) nested_d = 1'b1;
      end
      ST_IN_TRAP: begin
        // trap_ret takes the cycle; a simultaneous ecall only flags the error.
        if (trap_ret) state_d = ST_RETURN;
        if (ecall) nested_d = 1'b1;
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
        if (ecall) nested_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      is_irq_q <= 1'b0;
      claim_q  <= '0;
      nested_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      is_irq_q <= is_irq_d;
      claim_q  <= claim_d;
      nested_q <= nested_d;
    end
  end

  assign trigger_trap     = (state_q == ST_ENTER);
  assign trigger_trap_ret = (state_q == ST_RETURN);
  assign trapping         = (state_q == ST_ENTER) || (state_q == ST_IN_TRAP);
  assign cause            = cause_q;
  assign cause_is_irq     = is_irq_q;
  // claim_q is zero for an ecall entry, so this is only non-zero for IRQ traps.
  assign irq_claim        = (state_q == ST_ENTER) ? claim_q : '0;
  assign nested_err       = nested_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_trap_ctrl
// Self-checking bench for irq_trap_ctrl (NUM_IRQ=4, SYNC_STAGES=2, irq0 edge,
// irq1..3 level). Expected trap records {cause_is_irq, irq_claim, cause} are
// queued when stimulus is driven and compared on every trigger_trap pulse.
// -----------------------------------------------------------------------------
module tb_irq_trap_ctrl;
  import trap_pkg::*;

  localparam int NUM_IRQ = 4;
  localparam int CW      = 5;
  localparam int W       = 1 + NUM_IRQ + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_IRQ-1:0] irq, irq_en;
  logic               global_ie, ecall, trap_ret, pipe_ready;
  logic               trapping, trigger_trap, trigger_trap_ret;
  logic [CW-1:0]      cause;
  logic               cause_is_irq;
  logic [NUM_IRQ-1:0] irq_claim, pending;
  logic               nested_err;
  logic [1:0]         state_dbg;

  irq_trap_ctrl #(
    .NUM_IRQ        (NUM_IRQ),
    .SYNC_STAGES    (2),
    .IRQ_EDGE       (4'b0001),
    .CAUSE_W        (CW),
    .ECALL_CAUSE    (11),
    .IRQ_CAUSE_BASE (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq              (irq),
    .irq_en           (irq_en),
    .global_ie        (global_ie),
    .ecall            (ecall),
    .trap_ret         (trap_ret),
    .pipe_ready       (pipe_ready),
    .trapping         (trapping),
    .trigger_trap     (trigger_trap),
    .trigger_trap_ret (trigger_trap_ret),
    .cause            (cause),
    .cause_is_irq     (cause_is_irq),
    .irq_claim        (irq_claim),
    .pending          (pending),
    .nested_err       (nested_err),
    .state_dbg        (state_dbg)
  );

  int checks  = 0;
  int errors  = 0;
  int ret_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic is_irq, input logic [NUM_IRQ-1:0] claim,
                                      input logic [CW-1:0] c);
    return {is_irq, claim, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_for_trap(input int budget);
    int n = 0;
    while (!trigger_trap && n < budget) begin
      step(1);
      n++;
    end
    if (!trigger_trap) check_eq("trap_timeout", trigger_trap, 1);
  endtask

  // Called in IN_TRAP; leaves the FSM back in IDLE.
  task automatic do_mret();
    check_eq("pre_mret_state", state_dbg, ST_IN_TRAP);
    trap_ret = 1'b1;
    step(1);
    check_eq("ret_pulse", trigger_trap_ret, 1);
    check_eq("ret_trapping", trapping, 0);
    trap_ret = 1'b0;
    step(1);
    check_eq("ret_idle", state_dbg, ST_IDLE);
    check_eq("ret_pulse_end", trigger_trap_ret, 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && trigger_trap) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_trap", trigger_trap, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("trap_rec", {cause_is_irq, irq_claim, cause}, e);
      end
    end
    if (trigger_trap_ret) ret_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rc;
    rst_n = 1'b0; irq = '0; irq_en = '0; global_ie = 1'b0;
    ecall = 1'b0; trap_ret = 1'b0; pipe_ready = 1'b0;
    step(2);
    check_eq("rst_trapping", trapping, 0);
    check_eq("rst_trig", trigger_trap, 0);
    check_eq("rst_trig_ret", trigger_trap_ret, 0);
    check_eq("rst_cause", cause, 0);
    check_eq("rst_is_irq", cause_is_irq, 0);
    check_eq("rst_claim", irq_claim, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_nested", nested_err, 0);
    check_eq("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    step(1);

    // ecall in IDLE: trap next cycle
    pipe_ready = 1'b1;
    ecall = 1'b1;
    exp_q.push_back(mk(1'b0, 4'b0000, 5'd11));
    step(1);
    check_eq("ecall_trig", trigger_trap, 1);
    check_eq("ecall_cause", cause, 11);
    check_eq("ecall_is_irq", cause_is_irq, 0);
    check_eq("ecall_trapping", trapping, 1);
    ecall = 1'b0;
    step(1);
    check_eq("ecall_pulse_end", trigger_trap, 0);
    check_eq("ecall_in_trap", trapping, 1);
    do_mret();

    // level irq[2]: trap after SYNC_STAGES edges
    global_ie = 1'b1;
    irq_en = 4'b0100;
    irq = 4'b0100;
    exp_q.push_back(mk(1'b1, 4'b0100, 5'd18));
    step(1);
    check_eq("lvl_e0_trig", trigger_trap, 0);
    step(1);
    check_eq("lvl_e1_pending", pending, 4'b0100);
    check_eq("lvl_e1_trig", trigger_trap, 0);
    step(1);
    check_eq("lvl_e2_trig", trigger_trap, 1);
    check_eq("lvl_cause", cause, 18);
    check_eq("lvl_claim", irq_claim, 4'b0100);
    irq = '0;
    step(1);
    check_eq("lvl_claim_end", irq_claim, 0);
    do_mret();

    // global_ie=0 blocks a pending irq; enabling it takes the trap
    global_ie = 1'b0;
    irq = 4'b0100;
    step($urandom_range(4, 8));
    check_eq("gie_off_state", state_dbg, ST_IDLE);
    check_eq("gie_off_pending", pending, 4'b0100);
    exp_q.push_back(mk(1'b1, 4'b0100, 5'd18));
    global_ie = 1'b1;
    wait_for_trap(5);
    irq = '0;
    step(1);
    do_mret();

    // priority: ecall > irq1 > irq3
    pipe_ready = 1'b0;
    irq_en = 4'b1010;
    irq = 4'b1010;
    step(2);
    check_eq("prio_pending", pending, 4'b1010);
    check_eq("prio_hold_state", state_dbg, ST_IDLE);
    ecall = 1'b1;
    pipe_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 4'b0000, 5'd11));
    exp_q.push_back(mk(1'b1, 4'b0010, 5'd17));
    exp_q.push_back(mk(1'b1, 4'b1000, 5'd19));
    step(1);
    check_eq("prio_ecall_cause", cause, 11);
    ecall = 1'b0;
    step(1);
    do_mret();
    wait_for_trap(5);
    check_eq("prio_irq1_cause", cause, 17);
    irq[1] = 1'b0;
    step(1);
    do_mret();
    wait_for_trap(5);
    check_eq("prio_irq3_cause", cause, 19);
    irq[3] = 1'b0;
    step(1);
    do_mret();

    // edge irq[0] pulse held while pipe_ready=0
    irq_en = 4'b0001;
    pipe_ready = 1'b0;
    irq[0] = 1'b1;
    step(1);
    irq[0] = 1'b0;
    step(9);
    check_eq("edge_held", pending, 4'b0001);
    check_eq("edge_hold_state", state_dbg, ST_IDLE);
    exp_q.push_back(mk(1'b1, 4'b0001, 5'd16));
    pipe_ready = 1'b1;
    wait_for_trap(5);
    check_eq("edge_claim", irq_claim, 4'b0001);
    step(1);
    check_eq("edge_cleared", pending, 0);
    do_mret();

    // trap_ret + ecall in IN_TRAP: return wins, nested_err set, no re-entry
    check_eq("nested_clean", nested_err, 0);
    ecall = 1'b1;
    exp_q.push_back(mk(1'b0, 4'b0000, 5'd11));
    step(1);
    ecall = 1'b0;
    step(1);
    check_eq("nest_in_trap", state_dbg, ST_IN_TRAP);
    ecall = 1'b1;
    trap_ret = 1'b1;
    step(1);
    check_eq("nest_ret_pulse", trigger_trap_ret, 1);
    check_eq("nest_err", nested_err, 1);
    ecall = 1'b0;
    trap_ret = 1'b0;
    step(5);
    check_eq("nest_no_reentry", state_dbg, ST_IDLE);
    check_eq("nest_err_sticky", nested_err, 1);

    // reset in the middle of a trap
    ecall = 1'b1;
    exp_q.push_back(mk(1'b0, 4'b0000, 5'd11));
    step(1);
    ecall = 1'b0;
    step(1);
    check_eq("mid_rst_in_trap", trapping, 1);
    rc = ret_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_trapping", trapping, 0);
    check_eq("mid_rst_trig", trigger_trap, 0);
    check_eq("mid_rst_trig_ret", trigger_trap_ret, 0);
    check_eq("mid_rst_cause", cause, 0);
    check_eq("mid_rst_is_irq", cause_is_irq, 0);
    check_eq("mid_rst_nested", nested_err, 0);
    check_eq("mid_rst_state", state_dbg, ST_IDLE);
    step(2);
    rst_n = 1'b1;
    step(5);
    check_eq("mid_rst_no_ret", ret_cnt, rc);
    check_eq("mid_rst_idle", state_dbg, ST_IDLE);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_trap_ctrl.md
IRQ_TRAP_CTRL -- requirements
Module: irq_trap_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4: number of external interrupt sources, range 1..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth per IRQ input, range 2..4.
REQ-003 SHALL have parameter IRQ_EDGE, default all-zero, NUM_IRQ bits: bit i=1 makes source i edge-triggered, 0 makes it level-triggered.
REQ-004 SHALL have parameter CAUSE_W, default 5: cause code width.
REQ-005 SHALL have parameter ECALL_CAUSE, default 11: cause code reported for ecall.
REQ-006 SHALL have parameter IRQ_CAUSE_BASE, default 16: cause code reported for irq 0; irq i reports base+i.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  system clock, all state on rising edge.
REQ-009 Rst_n  in  1  asynchronous active-low reset.
REQ-010 irq  in  NUM_IRQ  raw interrupt requests, asynchronous to clk.
REQ-011 irq_en  in  NUM_IRQ  per-source enable mask (mie).
REQ-012 global_ie  in  1  global interrupt enable (mstatus.MIE).
REQ-013 ecall  in  1  synchronous ecall request from decode.
REQ-014 trap_ret  in  1  mret request from decode.
REQ-015 pipe_ready  in  1  pipeline can accept redirect (RAS_rdy & ~mem_hold).
REQ-016 trapping  out  1  handler active.
REQ-017 trigger_trap  out  1  one-cycle pulse: fetch redirects to mtvec, CSR captures mepc.
REQ-018 trigger_trap_ret  out  1  one-cycle pulse: fetch redirects to mepc.
REQ-019 cause  out  CAUSE_W  cause of the current/last trap.
REQ-020 cause_is_irq  out  1  1 = interrupt, 0 = ecall.
REQ-021 irq_claim  out  NUM_IRQ  one-hot, coincident with trigger_trap for an IRQ trap, else zero.
REQ-022 pending  out  NUM_IRQ  current pending vector (mip view).
REQ-023 nested_err  out  1  sticky: ecall received while trapping.

Function
REQ-024 Each irq bit SHALL pass a SYNC_STAGES-flop synchronizer; edge sources SHALL set pending on a synchronized 0->1 edge and hold it until claimed; level sources SHALL have pending equal to the synchronized value.
REQ-025 FSM states SHALL be IDLE, ENTER, IN_TRAP, RETURN; trigger_trap = (state==ENTER), trigger_trap_ret = (state==RETURN), trapping = (state==ENTER or IN_TRAP).
REQ-026 IDLE->ENTER SHALL occur when pipe_ready & (ecall | global_ie & |(pending & irq_en)); otherwise the FSM SHALL remain in IDLE and pending SHALL be retained.
REQ-027 Priority: ecall over any IRQ; among IRQs, lowest index wins.
REQ-028 On IDLE->ENTER, cause and cause_is_irq SHALL be latched and held until the next entry.
REQ-029 ENTER->IN_TRAP unconditionally; IN_TRAP->RETURN on trap_ret; RETURN->IDLE unconditionally.
REQ-030 trap_ret outside IN_TRAP SHALL be ignored; IRQs SHALL NOT preempt while trapping (no nesting).
REQ-031 ecall in ENTER/IN_TRAP/RETURN SHALL set nested_err; trap_ret wins over ecall in the same IN_TRAP cycle, and that ecall is dropped.
REQ-032 Latency: ecall sampled at edge e0 -> trigger_trap high in the cycle after e0; level irq first sampled at e0 -> trigger_trap high after edge e0+SYNC_STAGES.
REQ-033 The claimed edge-pending bit SHALL clear on the edge leaving ENTER; an edge recurring in that same cycle SHALL re-set it (set wins).

Reset
REQ-034 Rst_n low SHALL asynchronously force state IDLE, synchronizers/pending/edge history 0, cause 0, cause_is_irq 0, nested_err 0; all outputs 0.
REQ-035 Reset mid-trap SHALL abandon the trap with no trigger_trap_ret pulse.

Structure
REQ-036 Package trap_pkg SHALL hold the FSM state enum, ECALL_CAUSE/IRQ_CAUSE_BASE defaults, and the cause type.
REQ-037 Sub-module irq_sync (one bit: synchronizer, edge detect, pending flop) SHALL be instantiated NUM_IRQ times.

Verification
REQ-038 ecall=1 for one cycle in IDLE, pipe_ready=1 -> trigger_trap pulse next cycle, cause=11, cause_is_irq=0, trapping=1.
REQ-039 Level irq[2]=1, irq_en=4'b0100, global_ie=1, SYNC_STAGES=2 -> trigger_trap 2 edges later, cause=18, irq_claim=4'b0100.
REQ-040 irq[1] and irq[3] both pending, and ecall, same cycle -> ecall taken (cause=11); after mret, irq[1] taken (cause=17), then irq[3] (cause=19).
REQ-041 Edge irq[0] pulse while pipe_ready=0 for 10 cycles -> pending[0] held, trap taken when pipe_ready=1, pending[0] cleared after claim.
REQ-042 In IN_TRAP assert trap_ret and ecall together -> trigger_trap_ret pulse, nested_err=1, no new trap entry.
REQ-043 Rst_n low during IN_TRAP -> all outputs 0 immediately, no trigger_trap_ret pulse after release.
